engine_scheduler: RTL

Issues pixel coordinates of one frame, in raster order, to a bank of NUM_ENGINES Mandelbrot engines, each independently. Tracks which engines are free and grants the next pixel to a free engine by round-robin. Sits between frame control and the engine bank, replacing lockstep distribution: an engine gets new work as soon as its result is accepted downstream. Downstream backpressure (queue full) stalls issue.

---
 rtl/engine_scheduler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/engine_scheduler.sv
// Raster-order pixel issuer for a bank of independent Mandelbrot engines.
// Free engines are tracked per bit and granted round-robin, one pixel per cycle.
module engine_scheduler #(
   parameter int NUM_ENGINES = 3,
   parameter int DATA_WIDTH  = 32,
   parameter int WIDTH       = 640,
   parameter int HEIGHT      = 480
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   stall,
   input  logic [NUM_ENGINES-1:0] eng_done,
   output logic [NUM_ENGINES-1:0] eng_start,
   output logic [DATA_WIDTH-1:0]  x0,
   output logic [DATA_WIDTH-1:0]  y0,
   output logic                   frame_busy,
   output logic                   frame_done
);

   localparam int PTR_W = $clog2(NUM_ENGINES);
   localparam int XW    = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

   state_t                 state_reg, state_next;
   logic [NUM_ENGINES-1:0] free_reg, free_next;
   logic [PTR_W-1:0]       ptr_reg;
   logic [XW-1:0]          xc_reg, xc_next;
   logic [YW-1:0]          yc_reg, yc_next;
   logic [NUM_ENGINES-1:0] eng_start_reg;
   logic [DATA_WIDTH-1:0]  x0_reg, y0_reg;
   logic                   frame_busy_reg, frame_done_reg;

   logic                   grant_valid;
   logic [PTR_W-1:0]       grant_idx;
   logic [NUM_ENGINES-1:0] grant_vec;
   logic                   last_pixel;

   // Round-robin search starting just after the last granted engine.
   always_comb begin
      int cand;
      cand        = 0;
      grant_valid = 1'b0;
      grant_idx   = ptr_reg;
      grant_vec   = '0;
      if (state_reg == ISSUE && !stall) begin
         for (int k = 1; k <= NUM_ENGINES; k++) begin
            cand = (int'(ptr_reg) + k) % NUM_ENGINES;
            if (!grant_valid && free_reg[cand]) begin
               grant_valid = 1'b1;
               grant_idx   = PTR_W'(cand);
            end
         end
      end
      if (grant_valid) grant_vec[grant_idx] = 1'b1;
   end

   assign last_pixel = (xc_reg == XW'(WIDTH - 1)) && (yc_reg == YW'(HEIGHT - 1));

   always_comb begin
      state_next = state_reg;
      xc_next    = xc_reg;
      yc_next    = yc_reg;
      case (state_reg)
         IDLE:  if (start) state_next = ISSUE;
         ISSUE: begin
            if (grant_valid) begin
               if (last_pixel) begin
                  xc_next    = '0;
                  yc_next    = '0;
                  state_next = DRAIN;
               end else if (xc_reg == XW'(WIDTH - 1)) begin
                  xc_next = '0;
                  yc_next = yc_reg + YW'(1);
               end else begin
                  xc_next = xc_reg + XW'(1);
               end
            end
         end
         DRAIN: if (&free_reg) state_next = DONE;
         DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A grant in the same cycle as a (stale) done leaves the engine busy.
   assign free_next = (free_reg | eng_done) & ~grant_vec;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg      <= IDLE;
         free_reg       <= '1;
         ptr_reg        <= PTR_W'(NUM_ENGINES - 1);
         xc_reg         <= '0;
         yc_reg         <= '0;
         eng_start_reg  <= '0;
         x0_reg         <= '0;
         y0_reg         <= '0;
         frame_busy_reg <= 1'b0;
         frame_done_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         free_reg       <= free_next;
         xc_reg         <= xc_next;
         yc_reg         <= yc_next;
         eng_start_reg  <= grant_vec;
         frame_busy_reg <= (state_next == ISSUE) || (state_next == DRAIN);
         frame_done_reg <= (state_next == DONE);
         if (grant_valid) begin
            ptr_reg <= grant_idx;
            x0_reg  <= DATA_WIDTH'(xc_reg);
            y0_reg  <= DATA_WIDTH'(yc_reg);
         end
      end
   end

   assign eng_start  = eng_start_reg;
   assign x0         = x0_reg;
   assign y0         = y0_reg;
   assign frame_busy = frame_busy_reg;
   assign frame_done = frame_done_reg;

endmodule
